addsub_serial: RTL and testbench

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_serial_pkg.sv | 13 +
 rtl/addsub_serial_digit.sv | 28 ++
 rtl/addsub_serial.sv | 127 ++++++++++++
 tb/tb_addsub_serial.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/addsub_serial_pkg.sv
// Shared constants and FSM state encoding for the digit-serial adder/subtractor.
package addsub_serial_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_serial_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice; also exposes the carry into its MSB.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, result and flags held until handshake.
//   state   | meaning
//   IDLE    | ready for a new operation
//   RUN     | one digit added per clock, N clocks total
//   DONE    | result valid, held until out_ready
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, s_q, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q, ovf_q, zero_q, neg_q;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] dx, dy, dsum;
  logic             dco, dcmsb;
  logic             last;

  assign idx  = IW'(int'(cnt) * DIGIT);
  assign last = (cnt == CW'(N - 1));
  assign dx   = a_q[idx +: DIGIT];
  assign dy   = b_q[idx +: DIGIT];

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (dx),
    .y    (dy),
    .ci   (carry),
    .sum  (dsum),
    .co   (dco),
    .cmsb (dcmsb)
  );

  // Result as it will look after this edge; flags are taken from it on the last digit.
  always_comb begin
    res_nxt              = s_q;
    res_nxt[idx +: DIGIT] = dsum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)              state_nxt = ST_RUN;
      ST_RUN:  if (last)                  state_nxt = ST_DONE;
      ST_DONE: if (out_ready)             state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          s_q   <= res_nxt;
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout_q <= dco;
            ovf_q  <= dco ^ dcmsb;
            zero_q <= (res_nxt == '0);
            neg_q  <= res_nxt[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and random operations on addsub_serial, checked against an arithmetic reference model.
module tb_addsub_serial;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0]  a, b, s;
  logic          cout, ovf, zero, neg;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(W), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void ref_model(input logic [W-1:0] ta, tb, input logic tc, ts,
                                    output logic [W-1:0] rs, output logic rc, rv);
    logic [W-1:0] eb;
    logic [W:0]   full;
    int           sa, sb, t;
    eb   = ts ? ~tb : tb;
    full = {1'b0, ta} + {1'b0, eb} + (W+1)'(tc ^ ts);
    rs   = full[W-1:0];
    rc   = full[W];
    sa   = $signed(ta);
    sb   = $signed(eb);
    t    = sa + sb + int'(tc ^ ts);
    rv   = (t > 32767) || (t < -32768);
  endfunction

  task automatic run_op(input logic [W-1:0] ta, tb, input logic tc, ts, input int hold);
    logic [W-1:0] es;
    logic         ec, ev;
    int           lat;
    ref_model(ta, tb, tc, ts, es, ec, ev);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 2) chk("ready_in_run", 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 20);
    chk("latency", 32'(lat), 32'(N));
    chk("s", 32'(s), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(ovf), 32'(ev));
    chk("zero", 32'(zero), 32'(es == '0));
    chk("neg", 32'(neg), 32'(es[W-1]));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_s", 32'(s), 32'(es));
      chk("hold_flags", {28'd0, cout, ovf, zero, neg},
          {28'd0, ec, ev, 1'(es == '0), es[W-1]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);

    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hC000, 16'hA500, 1'b1, 1'b0, 0);
    run_op(16'h0005, 16'h0005, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 3);

    // Abort during the second RUN cycle.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
